// File: rtl/imm_extend_pipe_if.sv
// -----------------------------------------------------------------------------
// imm_extend_pipe_if
//   Bundles both handshake channels of the immediate-extension stage plus the
//   pipeline flush. Signal names are written from the stage's point of view, so
//   the _i/_o suffixes read naturally inside the design.
//
//   Parameters
//     IN_W   width of the raw immediate
//     OUT_W  width of the extended operand
//
//   Signals
//     valid_i  upstream presents data_i/mode_i
//     ready_o  stage can accept this cycle
//     data_i   raw immediate (IN_W)
//     mode_i   00 sign, 01 zero, 10 upper, 11 branch
//     flush_i  synchronous pipeline flush
//     valid_o  data_o holds a valid extended operand
//     ready_i  downstream accepts this cycle
//     data_o   extended operand (OUT_W)
//
//   Modports
//     slave   the extension stage itself
//     master  the surrounding pipeline (producer, consumer and flush source)
// -----------------------------------------------------------------------------
interface imm_extend_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) ();

  logic             valid_i;
  logic             ready_o;
  logic [IN_W-1:0]  data_i;
  logic [1:0]       mode_i;
  logic             flush_i;
  logic             valid_o;
  logic             ready_i;
  logic [OUT_W-1:0] data_o;

  modport slave (
    input  valid_i,
    input  data_i,
    input  mode_i,
    input  flush_i,
    input  ready_i,
    output ready_o,
    output valid_o,
    output data_o
  );

  modport master (
    output valid_i,
    output data_i,
    output mode_i,
    output flush_i,
    output ready_i,
    input  ready_o,
    input  valid_o,
    input  data_o
  );

endinterface : imm_extend_pipe_if

// File: rtl/imm_extend_pipe.sv
// -----------------------------------------------------------------------------
// imm_extend_pipe
//   Registered immediate-extension stage between ID and the ID/EX boundary.
//   An IN_W-bit immediate is extended to an OUT_W-bit operand in one of four
//   modes (sign, zero, upper, branch offset) at the moment it is accepted, and
//   the result is held in a 2-entry buffer: an output register plus a skid
//   register. The skid entry absorbs the one word that can arrive in the same
//   cycle the consumer stalls, so nothing is dropped or duplicated and order is
//   strictly first-in first-out.
//
//   Parameters
//     IN_W   width of the immediate input
//     OUT_W  width of the extended output, must be at least IN_W+2 so that the
//            branch shift never loses sign information
//
//   Ports
//     clk_i  clock, rising edge
//     rst_i  asynchronous reset, active-high; clears both entries
//     bus    imm_extend_pipe_if.slave: valid_i/ready_o/data_i/mode_i in,
//            valid_o/ready_i/data_o out, flush_i
//
//   Timing
//     An immediate accepted on edge N is visible on data_o right after edge N
//     when the output register is free. ready_o and valid_o are decoded from
//     the occupancy register alone, so neither has a combinational path from
//     any input.
// -----------------------------------------------------------------------------
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  imm_extend_pipe_if.slave bus
);

  // Number of bits added on top of (or below) the raw immediate.
  localparam int S = OUT_W - IN_W;

  if (OUT_W < IN_W + 2) begin : g_bad_width
    $error("imm_extend_pipe: OUT_W must be at least IN_W+2");
  end

  typedef enum logic [1:0] {
    MODE_SIGN   = 2'b00,
    MODE_ZERO   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_BRANCH = 2'b11
  } mode_e;

  // Occupancy of the two-entry buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,  // nothing held
    ONE   = 2'b01,  // output register full
    TWO   = 2'b10   // output register and skid register full
  } state_e;

  // ---------------------------------------------------------------------------
  // Extension
  // ---------------------------------------------------------------------------
  function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm,
                                              input logic [1:0]      mode);
    logic [OUT_W-1:0] sext;
    sext = {{S{imm[IN_W-1]}}, imm};
    unique case (mode_e'(mode))
      MODE_SIGN:   extend = sext;
      MODE_ZERO:   extend = {{S{1'b0}}, imm};
      MODE_UPPER:  extend = {imm, {S{1'b0}}};
      // Word-aligned branch offset: the sign-extended value times four.
      MODE_BRANCH: extend = {sext[OUT_W-3:0], 2'b00};
    endcase
    return extend;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [OUT_W-1:0] out_q,   out_d;
  logic [OUT_W-1:0] skid_q,  skid_d;

  logic             acc;
  logic             pop;
  logic [OUT_W-1:0] ext_in;

  assign bus.ready_o = (state_q != TWO);
  assign bus.valid_o = (state_q != EMPTY);
  assign bus.data_o  = out_q;

  assign acc    = bus.valid_i & bus.ready_o;
  assign pop    = bus.valid_o & bus.ready_i;
  // mode_i only matters through this value, which is stored on accept; later
  // changes of mode_i cannot reach entries already held.
  assign ext_in = extend(bus.data_i, bus.mode_i);

  // NOTE: every variable written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;

    if (bus.flush_i) begin
      // Flush wins over any accept or pop this cycle; the offered word is
      // dropped and data_o keeps its last value.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d = ONE;
            out_d   = ext_in;
          end
        end
        ONE: begin
          if (acc && pop) begin
            out_d = ext_in;
          end else if (acc) begin
            // Consumer stalled while a new word arrived: park it behind.
            state_d = TWO;
            skid_d  = ext_in;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          // ready_o is low here, so only the drain side can move.
          if (pop) begin
            state_d = ONE;
            out_d   = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
  // A stalled, valid operand must stay put until the consumer takes it.
  a_stable_on_stall : assert property (
    @(posedge clk_i) disable iff (rst_i)
    (bus.valid_o && !bus.ready_i && !bus.flush_i) |=> (bus.valid_o && $stable(bus.data_o))
  );

  // A flush always empties the buffer on the following cycle.
  a_flush_empties : assert property (
    @(posedge clk_i) disable iff (rst_i)
    bus.flush_i |=> (!bus.valid_o && bus.ready_o)
  );

  // The buffer can never be full while reporting nothing valid.
  a_ready_implies : assert property (
    @(posedge clk_i) disable iff (rst_i)
    !bus.ready_o |-> bus.valid_o
  );

endmodule : imm_extend_pipe

// File: tb/tb_imm_extend_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_extend_pipe
//   Bench for imm_extend_pipe. Two instances: a 16->32 stage for the main
//   function, handshake, flush and reset cases, and a 12->32 stage for the
//   narrow-immediate case. Expected operands are hand-computed constants pushed
//   into a queue when the bench sees an offer accepted; a monitor per instance
//   pops and compares whenever the stage hands an operand downstream.
// -----------------------------------------------------------------------------
module tb_imm_extend_pipe;

  logic clk_i = 1'b0;
  logic rst_i;

  always #5 clk_i = ~clk_i;

  imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) bus_a ();
  imm_extend_pipe_if #(.IN_W(12), .OUT_W(32)) bus_b ();

  imm_extend_pipe #(.IN_W(16), .OUT_W(32)) u_dut_a (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus_a)
  );

  imm_extend_pipe #(.IN_W(12), .OUT_W(32)) u_dut_b (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got %h with no operand expected", name, act);
  endtask

  // ---------------------------------------------------------------------------
  // Monitors: sampled on the falling edge, where the values are the ones the
  // next rising edge will act on.
  // ---------------------------------------------------------------------------
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (bus_a.flush_i) begin
        exp_a.delete();
      end else if (bus_a.valid_o && bus_a.ready_i) begin
        if (exp_a.size() == 0) unexpected("a_data", bus_a.data_o);
        else                   check("a_data", bus_a.data_o, exp_a.pop_front());
      end
    end
  end

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (bus_b.flush_i) begin
        exp_b.delete();
      end else if (bus_b.valid_o && bus_b.ready_i) begin
        if (exp_b.size() == 0) unexpected("b_data", bus_b.data_o);
        else                   check("b_data", bus_b.data_o, exp_b.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Called just after a rising edge; send returns just after
  // the edge that accepted the word, leaving valid_i high for back-to-back use.
  // ---------------------------------------------------------------------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    bus_a.valid_i = 1'b0;
    bus_b.valid_i = 1'b0;
  endtask

  task automatic send(input bit to_b, input logic [15:0] data, input logic [1:0] mode,
                      input logic [31:0] expv);
    bit ok;
    ok = 1'b0;
    if (to_b) begin
      bus_b.valid_i = 1'b1;
      bus_b.data_i  = data[11:0];
      bus_b.mode_i  = mode;
    end else begin
      bus_a.valid_i = 1'b1;
      bus_a.data_i  = data;
      bus_a.mode_i  = mode;
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (to_b ? bus_b.ready_o : bus_a.ready_o) begin
        if (to_b) exp_b.push_back(expv);
        else      exp_a.push_back(expv);
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk_i);
    #1;
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: data %h never accepted", data);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_i         = 1'b1;
    bus_a.valid_i = 1'b0;  bus_a.data_i = '0;  bus_a.mode_i = '0;
    bus_a.flush_i = 1'b0;  bus_a.ready_i = 1'b1;
    bus_b.valid_i = 1'b0;  bus_b.data_i = '0;  bus_b.mode_i = '0;
    bus_b.flush_i = 1'b0;  bus_b.ready_i = 1'b1;

    // Reset state.
    #12;
    check("rst_valid_a", {31'd0, bus_a.valid_o}, 32'd0);
    check("rst_ready_a", {31'd0, bus_a.ready_o}, 32'd1);
    check("rst_data_a",  bus_a.data_o,           32'd0);
    check("rst_valid_b", {31'd0, bus_b.valid_o}, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    cycles(1);

    // 1: sign extension, visible right after the accepting edge.
    send(1'b0, 16'h8004, 2'b00, 32'hFFFF8004);
    check("t1_valid", {31'd0, bus_a.valid_o}, 32'd1);
    idle();
    cycles(2);

    // 2: all modes back to back with the consumer always ready.
    send(1'b0, 16'h8004, 2'b01, 32'h00008004);
    send(1'b0, 16'h1234, 2'b10, 32'h12340000);
    send(1'b0, 16'hFFFF, 2'b11, 32'hFFFFFFFC);
    send(1'b0, 16'h8004, 2'b11, 32'hFFFE0010);
    send(1'b0, 16'h7FFF, 2'b00, 32'h00007FFF);
    idle();
    @(negedge clk_i);
    #1;
    check("t2_drained", exp_a.size(), 32'd0);
    cycles(1);

    // 3: backpressure fills both entries, third offer waits.
    bus_a.ready_i = 1'b0;
    send(1'b0, 16'h0001, 2'b01, 32'h00000001);
    send(1'b0, 16'h0002, 2'b01, 32'h00000002);
    check("t3_ready_full", {31'd0, bus_a.ready_o}, 32'd0);
    check("t3_valid_full", {31'd0, bus_a.valid_o}, 32'd1);
    check("t3_head",       bus_a.data_o,           32'h00000001);
    fork
      send(1'b0, 16'h0003, 2'b01, 32'h00000003);
      begin
        cycles(3);
        check("t3_head_held", bus_a.data_o, 32'h00000001);
        bus_a.ready_i = 1'b1;
      end
    join
    idle();
    cycles(3);
    check("t3_drained", exp_a.size(), 32'd0);

    // 4: flush while full, with a word on offer in the same cycle.
    bus_a.ready_i = 1'b0;
    send(1'b0, 16'h0011, 2'b01, 32'h00000011);
    send(1'b0, 16'h0022, 2'b01, 32'h00000022);
    bus_a.valid_i = 1'b1;
    bus_a.data_i  = 16'h00EE;
    bus_a.mode_i  = 2'b01;
    bus_a.flush_i = 1'b1;
    cycles(1);
    bus_a.flush_i = 1'b0;
    idle();
    check("t4_valid", {31'd0, bus_a.valid_o}, 32'd0);
    check("t4_ready", {31'd0, bus_a.ready_o}, 32'd1);
    bus_a.ready_i = 1'b1;
    cycles(3);
    send(1'b0, 16'h0055, 2'b01, 32'h00000055);
    idle();
    cycles(2);

    // 5: asynchronous reset between edges while one entry is held.
    bus_a.ready_i = 1'b0;
    send(1'b0, 16'h00AA, 2'b01, 32'h000000AA);
    idle();
    #1;
    rst_i = 1'b1;
    #1;
    check("t5_valid", {31'd0, bus_a.valid_o}, 32'd0);
    check("t5_data",  bus_a.data_o,           32'd0);
    check("t5_ready", {31'd0, bus_a.ready_o}, 32'd1);
    exp_a.delete();
    #1;
    rst_i = 1'b0;
    bus_a.ready_i = 1'b1;
    cycles(1);
    send(1'b0, 16'h0077, 2'b00, 32'h00000077);
    idle();
    cycles(2);

    // 6: narrow 12-bit immediate.
    send(1'b1, 16'h0800, 2'b00, 32'hFFFFF800);
    send(1'b1, 16'h0800, 2'b10, 32'h80000000);
    send(1'b1, 16'h0800, 2'b01, 32'h00000800);
    send(1'b1, 16'h0800, 2'b11, 32'hFFFFE000);
    idle();
    cycles(3);

    check("end_empty_a", exp_a.size(), 32'd0);
    check("end_empty_b", exp_b.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_imm_extend_pipe
